// File: rtl/multicycle_core.sv
// -----------------------------------------------------------------------------
// multicycle_core
//
// Multi-cycle MIPS-subset core. A single FSM steps each instruction through
// FETCH / DECODE / EXEC / MEM / WB. Instructions and data share one memory
// port that uses a req/ready handshake, so the memory may insert wait states.
// Any unsupported opcode/funct, or a misaligned lw/sw address, puts the core
// into HALT, where it stays until reset.
//
// Supported: add sub and or slt (R-type), lw, sw, beq, addi, j.
//
// Parameters:
//   ADDR_W    width of the PC and of mem_addr (8..32)
//   RESET_PC  PC loaded on reset (word-aligned)
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   mem_req    memory request valid
//   mem_we     1 = write (sw), 0 = read
//   mem_addr   byte address, word-aligned whenever mem_req=1
//   mem_wdata  store data
//   mem_rdata  read data, valid in the cycle mem_ready=1
//   mem_ready  transfer completes on a rising edge with mem_req=1, mem_ready=1
//   halted     core stopped
//   pc_out     current PC (debug)
// -----------------------------------------------------------------------------
module multicycle_core #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state, next_state;

  // Architectural and inter-stage registers
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic [31:0]       alu_out;
  logic [31:0]       mdr;
  logic [31:0]       regs [32];

  // Instruction fields
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  funct;
  logic [31:0] sext_imm;
  logic [31:0] pc32;
  logic [31:0] jump_target;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign pc32     = 32'(pc);
  // Jump keeps the top nibble of the already-incremented PC.
  assign jump_target = {pc32[31:28], ir[25:0], 2'b00};

  // Decode
  logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, legal;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block
    // leaves it unassigned, which would infer a latch.
    is_rtype = 1'b0;
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_beq   = (op == OP_BEQ);
    is_addi  = (op == OP_ADDI);
    is_j     = (op == OP_J);
    if (op == OP_RTYPE) begin
      case (funct)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_rtype = 1'b1;
        default:                               is_rtype = 1'b0;
      endcase
    end
    legal = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;
  end

  // ALU: R-type uses B, everything else that reaches EXEC adds the immediate.
  logic [31:0] alu_b;
  logic [31:0] alu_result;

  always_comb begin
    alu_b      = is_rtype ? b_reg : sext_imm;
    alu_result = a_reg + alu_b;
    if (is_rtype) begin
      case (funct)
        FN_SUB:  alu_result = a_reg - b_reg;
        FN_AND:  alu_result = a_reg & b_reg;
        FN_OR:   alu_result = a_reg | b_reg;
        FN_SLT:  alu_result = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
        default: alu_result = a_reg + b_reg;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   next_state = S_FETCH;
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (!legal)    next_state = S_HALT;
        else if (is_j) next_state = S_FETCH;
        else           next_state = S_EXEC;
      end
      S_EXEC: begin
        if (is_lw || is_sw)
          next_state = (alu_result[1:0] != 2'b00) ? S_HALT : S_MEM;
        else if (is_beq)
          next_state = S_FETCH;
        else
          next_state = S_WB;
      end
      S_MEM:    if (mem_ready) next_state = is_sw ? S_FETCH : S_WB;
      S_WB:     next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_HALT;
    endcase
  end

  // FSM: outputs. Decoded from state alone, so an asynchronous reset drops
  // mem_req at once and the request fields hold steady while waiting.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_out[ADDR_W-1:0];
        if (is_sw) begin
          mem_we    = 1'b1;
          mem_wdata = b_reg;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign pc_out = pc;

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      // NOTE: the register file is built from flops and is cleared on reset;
      // it is never mapped to a RAM macro, so the reset loop is legal.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + ADDR_W'(32'd4);
          end
        end
        S_DECODE: begin
          // regs[0] is never written, so it always reads as zero.
          a_reg   <= regs[rs];
          b_reg   <= regs[rt];
          alu_out <= pc32 + (sext_imm << 2);
          if (is_j) pc <= jump_target[ADDR_W-1:0];
        end
        S_EXEC: begin
          if (is_beq) begin
            if (a_reg == b_reg) pc <= alu_out[ADDR_W-1:0];
          end else begin
            alu_out <= alu_result;
          end
        end
        S_MEM: begin
          if (mem_ready && is_lw) mdr <= mem_rdata;
        end
        S_WB: begin
          if (is_rtype) begin
            if (rd != 5'd0) regs[rd] <= alu_out;
          end else if (is_addi) begin
            if (rt != 5'd0) regs[rt] <= alu_out;
          end else if (is_lw) begin
            if (rt != 5'd0) regs[rt] <= mdr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_core.sv
// -----------------------------------------------------------------------------
// tb_multicycle_core
//
// Directed bench for multicycle_core (ADDR_W=16, RESET_PC=0x40). A small
// memory responder serves the unified port with a programmable number of wait
// cycles and logs every completed transfer. The program exercises every ALU op,
// $0 write discard, sw/lw, taken and not-taken beq and j, and ends in a halt.
// -----------------------------------------------------------------------------
module tb_multicycle_core;

  logic        clock;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halted;
  logic [15:0] pc_out;

  multicycle_core #(
    .ADDR_W   (16),
    .RESET_PC (16'h0040)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc_out    (pc_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Memory model and transfer log
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          cyc;
  } xfer_t;

  logic [31:0] mem [128];
  xfer_t       trace [$];
  int          cyc_count   = 0;
  int          wait_cycles = 0;
  int          wait_cnt    = 0;
  logic        prev_wait   = 1'b0;
  logic [15:0] prev_addr;
  logic        prev_we;
  logic [31:0] prev_wdata;

  always @(posedge clock) cyc_count++;

  // Inputs change on the falling edge; the decision made here completes on
  // the following rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      wait_cnt  = 0;
      prev_wait = 1'b0;
      mem_ready = (wait_cycles == 0);
    end else begin
      mem_ready = (wait_cnt >= wait_cycles);
      mem_rdata = mem[mem_addr[8:2]];
      if (prev_wait && mem_req) begin
        check("stable_addr", 32'(mem_addr), 32'(prev_addr));
        check("stable_we", 32'(mem_we), 32'(prev_we));
        check("stable_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req) begin
        if (mem_ready) begin
          trace.push_back('{addr: 32'(mem_addr), we: mem_we, wdata: mem_wdata,
                            cyc: cyc_count});
          if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
    end
  end

  // Expected transfer sequence (same for both runs; the final fetch at 0x100
  // halts either on alignment or on an illegal opcode).
  localparam int N_XFER = 33;
  logic [31:0] exp_addr [N_XFER] = '{
    32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h180, 32'h58, 32'h184,
    32'h5C, 32'h188, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h18C, 32'h74,
    32'h190, 32'h78, 32'h194, 32'h7C, 32'h198, 32'h80, 32'h8, 32'h84, 32'h8,
    32'h88, 32'h19C, 32'h8C, 32'h98, 32'h9C, 32'h100};
  logic        exp_we [N_XFER] = '{
    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1,
    0, 0, 0, 1, 0, 0, 0, 0};
  logic [31:0] exp_wd [N_XFER] = '{
    0, 0, 0, 0, 0, 0, 32'd2, 0, 32'd1, 0, 32'd0, 0, 0, 0, 0, 0, 32'd8, 0,
    32'd5, 0, 32'hFFFF_FFFD, 0, 32'd0, 0, 32'd5, 0, 0, 0, 32'd5, 0, 0, 0, 0};

  task automatic load_program();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[16] = 32'h2001_0005;  // 0x40 addi $1,$0,5
    mem[17] = 32'h2002_FFFD;  // 0x44 addi $2,$0,-3
    mem[18] = 32'h0022_1820;  // 0x48 add  $3,$1,$2   -> 2
    mem[19] = 32'h0041_202A;  // 0x4C slt  $4,$2,$1   -> 1
    mem[20] = 32'h2000_0007;  // 0x50 addi $0,$0,7    -> $0 stays 0
    mem[21] = 32'hAC03_0180;  // 0x54 sw $3,0x180($0)
    mem[22] = 32'hAC04_0184;  // 0x58 sw $4,0x184($0)
    mem[23] = 32'hAC00_0188;  // 0x5C sw $0,0x188($0)
    mem[24] = 32'h0022_3022;  // 0x60 sub  $6,$1,$2   -> 8
    mem[25] = 32'h0022_3824;  // 0x64 and  $7,$1,$2   -> 5
    mem[26] = 32'h0022_4025;  // 0x68 or   $8,$1,$2   -> 0xFFFFFFFD
    mem[27] = 32'h0022_482A;  // 0x6C slt  $9,$1,$2   -> 0 (signed)
    mem[28] = 32'hAC06_018C;  // 0x70 sw $6,0x18C($0)
    mem[29] = 32'hAC07_0190;  // 0x74 sw $7,0x190($0)
    mem[30] = 32'hAC08_0194;  // 0x78 sw $8,0x194($0)
    mem[31] = 32'hAC09_0198;  // 0x7C sw $9,0x198($0)
    mem[32] = 32'hAC01_0008;  // 0x80 sw $1,8($0)
    mem[33] = 32'h8C05_0008;  // 0x84 lw $5,8($0)
    mem[34] = 32'hAC05_019C;  // 0x88 sw $5,0x19C($0)
    mem[35] = 32'h1021_0002;  // 0x8C beq $1,$1,+2    -> 0x98
    mem[36] = 32'hFC00_0000;  // 0x90 skipped
    mem[37] = 32'hFC00_0000;  // 0x94 skipped
    mem[38] = 32'h1022_0005;  // 0x98 beq $1,$2,+5    not taken -> 0x9C
    mem[39] = 32'h0800_0040;  // 0x9C j 0x40          -> 0x100
    mem[64] = 32'h8C0A_0006;  // 0x100 lw $10,6($0)   misaligned -> halt
    mem[98]  = 32'hDEAD_BEEF; // 0x188 overwritten with $0
    mem[102] = 32'h1234_5678; // 0x198 overwritten with slt result 0
  endtask

  task automatic run_to_halt(input string tag);
    int n = 0;
    while (!halted && n < 3000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  task automatic check_trace(input string run);
    check($sformatf("%s_xfer_count", run), trace.size(), N_XFER);
    for (int i = 0; i < N_XFER && i < trace.size(); i++) begin
      check($sformatf("%s_addr[%0d]", run, i), trace[i].addr, exp_addr[i]);
      check($sformatf("%s_we[%0d]", run, i), 32'(trace[i].we), 32'(exp_we[i]));
      if (exp_we[i])
        check($sformatf("%s_wdata[%0d]", run, i), trace[i].wdata, exp_wd[i]);
    end
  endtask

  initial begin
    reset       = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = 32'h0;
    wait_cycles = 0;
    load_program();

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clock);
      #1;
      check("reset_mem_req", 32'(mem_req), 32'd0);
    end
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_pc", 32'(pc_out), 32'h40);

    // Release: IDLE on the first edge, fetch from the vector after it
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("first_fetch_req", 32'(mem_req), 32'd1);
    check("first_fetch_addr", 32'(mem_addr), 32'h40);
    check("first_fetch_we", 32'(mem_we), 32'd0);

    // Run 1: zero wait states, ends on the misaligned lw
    run_to_halt("run1_halted");
    repeat (10) @(posedge clock);
    #1;
    check("run1_halt_no_req", 32'(mem_req), 32'd0);
    check("run1_halt_pc", 32'(pc_out), 32'h104);
    check_trace("run1");
    if (trace.size() == N_XFER) begin
      check("lat_addi", trace[1].cyc - trace[0].cyc, 4);
      check("lat_add", trace[3].cyc - trace[2].cyc, 4);
      check("lat_sw", trace[7].cyc - trace[5].cyc, 4);
      check("lat_lw", trace[27].cyc - trace[25].cyc, 5);
      check("lat_beq_taken", trace[30].cyc - trace[29].cyc, 3);
      check("lat_beq_not_taken", trace[31].cyc - trace[30].cyc, 3);
    end
    check("mem_add", mem[96], 32'd2);
    check("mem_slt_true", mem[97], 32'd1);
    check("mem_r0", mem[98], 32'd0);
    check("mem_sub", mem[99], 32'd8);
    check("mem_and", mem[100], 32'd5);
    check("mem_or", mem[101], 32'hFFFF_FFFD);
    check("mem_slt_signed", mem[102], 32'd0);
    check("mem_sw8", mem[2], 32'd5);
    check("mem_lw5", mem[103], 32'd5);

    // Run 2: three wait cycles per request, reset mid-transfer, then an
    // illegal opcode at 0x100
    reset = 1'b0;
    for (int i = 96; i < 104; i++) mem[i] = 32'hA5A5_A5A5;
    mem[2]      = 32'h0;
    mem[64]     = 32'hFC00_0000;
    wait_cycles = 3;
    repeat (2) @(negedge clock);
    trace.delete();
    reset = 1'b1;
    begin
      int n = 0;
      while (!(mem_req && mem_we && !mem_ready) && n < 500) begin
        @(negedge clock);
        #1;
        n++;
      end
      check("found_waiting_store", 32'(mem_req && mem_we && !mem_ready), 32'd1);
      check("waiting_store_addr", 32'(mem_addr), 32'h180);
    end
    reset = 1'b0;
    #1;
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clock);
    check("abort_no_write", mem[96], 32'hA5A5_A5A5);
    trace.delete();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("refetch_req", 32'(mem_req), 32'd1);
    check("refetch_addr", 32'(mem_addr), 32'h40);

    run_to_halt("run2_halted");
    repeat (10) @(posedge clock);
    #1;
    check("run2_halt_no_req", 32'(mem_req), 32'd0);
    check("run2_halt_pc", 32'(pc_out), 32'h104);
    check_trace("run2");
    if (trace.size() == N_XFER) begin
      // Each request waits 3 cycles: one request for addi, two for sw/lw.
      check("lat_addi_wait", trace[1].cyc - trace[0].cyc, 7);
      check("lat_sw_wait", trace[7].cyc - trace[5].cyc, 10);
      check("lat_lw_wait", trace[27].cyc - trace[25].cyc, 11);
    end
    check("mem_add_wait", mem[96], 32'd2);
    check("mem_sw8_wait", mem[2], 32'd5);
    check("mem_lw5_wait", mem[103], 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
